// File: rtl/output_level_ramp.sv
// Output level stage: scales the double-width overdrive sample by a gain that glides one LSB
// at a time toward its (mute-aware) target, then saturates back to fxp_size. Two-stage pipeline.
module output_level_ramp #(
    parameter int fxp_size           = 16,
    parameter int bits_per_level     = 12,
    parameter int bits_per_gain_frac = 4,
    parameter int ramp_div           = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [2*fxp_size-1:0]   i_sample,
    input  logic [fxp_size-1:0]     i_target_gain,
    input  logic                    i_mute,
    output logic                    o_valid,
    output logic [fxp_size-1:0]     o_sample,
    output logic                    o_clip,
    output logic                    o_ramping,
    output logic [fxp_size-1:0]     o_cur_gain
);

    localparam int PW   = 3 * fxp_size + 1;
    localparam int CntW = (ramp_div > 1) ? $clog2(ramp_div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ramp_div - 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    // The sample format passes through unchanged; the level fraction must fit in the output word.
    if (bits_per_level >= fxp_size) begin : g_bad_level_format
    end

    // Clamp a shifted product to the signed output range; returns {clip, sample}.
    function automatic logic [fxp_size:0] sat_fn(input logic signed [PW-1:0] val);
        logic [PW-fxp_size:0] upper;
        logic [fxp_size:0]    res;
        upper = val[PW-1:fxp_size-1];
        if ((upper == '0) || (upper == '1)) begin
            res = {1'b0, val[fxp_size-1:0]};
        end else if (val[PW-1]) begin
            res = {1'b1, 1'b1, {(fxp_size-1){1'b0}}};
        end else begin
            res = {1'b1, 1'b0, {(fxp_size-1){1'b1}}};
        end
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [fxp_size-1:0]    cur_gain_q, cur_gain_d;
    logic [CntW-1:0]        step_cnt_q, step_cnt_d;
    logic                   ramping_q, ramping_d;
    logic                   v1_q, v1_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic                   v2_q, v2_d;
    logic [fxp_size-1:0]    sample_q, sample_d;
    logic                   clip_q, clip_d;

    logic [fxp_size-1:0]    tgt_s;
    logic signed [PW-1:0]   samp_ext_s;
    logic signed [PW-1:0]   gain_ext_s;
    logic signed [PW-1:0]   shifted_s;
    logic [fxp_size:0]      sat_s;

    // Gain FSM: steps only on accepted samples, re-deciding direction every sample.
    always_comb begin
        tgt_s      = i_mute ? '0 : i_target_gain;
        state_d    = state_q;
        cur_gain_d = cur_gain_q;
        step_cnt_d = step_cnt_q;
        if (i_valid) begin
            if (cur_gain_q == tgt_s) begin
                state_d    = HOLD;
                step_cnt_d = '0;
            end else begin
                if (step_cnt_q == CntMax) begin
                    step_cnt_d = '0;
                    if (tgt_s > cur_gain_q) begin
                        cur_gain_d = cur_gain_q + fxp_size'(1);
                    end else begin
                        cur_gain_d = cur_gain_q - fxp_size'(1);
                    end
                end else begin
                    step_cnt_d = step_cnt_q + CntW'(1);
                end
                // Reaching the target ends the ramp; a reversal keeps the partial step count.
                if (cur_gain_d == tgt_s) begin
                    state_d    = HOLD;
                    step_cnt_d = '0;
                end else if (tgt_s > cur_gain_d) begin
                    state_d = RAMP_UP;
                end else begin
                    state_d = RAMP_DOWN;
                end
            end
        end else begin
            state_d    = state_q;
            cur_gain_d = cur_gain_q;
            step_cnt_d = step_cnt_q;
        end
        ramping_d = (state_d != HOLD);
    end

    // Datapath: multiply with the pre-update gain, then shift and saturate.
    always_comb begin
        samp_ext_s = {{(PW-2*fxp_size){i_sample[2*fxp_size-1]}}, i_sample};
        gain_ext_s = {{(PW-fxp_size){1'b0}}, cur_gain_q};
        v1_d       = i_valid;
        if (i_valid) begin
            prod_d = samp_ext_s * gain_ext_s;
        end else begin
            prod_d = prod_q;
        end
        shifted_s = prod_q >>> bits_per_gain_frac;
        sat_s     = sat_fn(shifted_s);
        v2_d      = v1_q;
        if (v1_q) begin
            sample_d = sat_s[fxp_size-1:0];
            clip_d   = sat_s[fxp_size];
        end else begin
            sample_d = sample_q;
            clip_d   = 1'b0;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HOLD;
            cur_gain_q <= '0;
            step_cnt_q <= '0;
            ramping_q  <= 1'b0;
            v1_q       <= 1'b0;
            prod_q     <= '0;
            v2_q       <= 1'b0;
            sample_q   <= '0;
            clip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_gain_q <= cur_gain_d;
            step_cnt_q <= step_cnt_d;
            ramping_q  <= ramping_d;
            v1_q       <= v1_d;
            prod_q     <= prod_d;
            v2_q       <= v2_d;
            sample_q   <= sample_d;
            clip_q     <= clip_d;
        end
    end

    assign o_valid    = v2_q;
    assign o_sample   = sample_q;
    assign o_clip     = clip_q;
    assign o_ramping  = ramping_q;
    assign o_cur_gain = cur_gain_q;

endmodule

// File: tb/tb_output_level_ramp.sv
// Directed bench for output_level_ramp with ramp_div=4: fade-in, saturation, ramp down,
// mute, reversal, async reset and sparse strobes, all against hand-computed values.
module tb_output_level_ramp;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_sample;
    logic [15:0] i_target_gain;
    logic        i_mute;
    logic        o_valid;
    logic [15:0] o_sample;
    logic        o_clip;
    logic        o_ramping;
    logic [15:0] o_cur_gain;

    int n_cmp;
    int n_bad;
    int max_gain;
    int vcount;

    output_level_ramp #(
        .fxp_size(16), .bits_per_level(12), .bits_per_gain_frac(4), .ramp_div(4)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sample(i_sample),
        .i_target_gain(i_target_gain), .i_mute(i_mute), .o_valid(o_valid),
        .o_sample(o_sample), .o_clip(o_clip), .o_ramping(o_ramping), .o_cur_gain(o_cur_gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
    endtask

    // One strobe, then one idle cycle: the result is on the outputs afterwards.
    task automatic pulse(input logic [31:0] s);
        i_sample = s;
        i_valid  = 1'b1;
        tick();
        i_valid  = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        i_valid = 1'b0;
        i_sample = 32'h0000_0100;
        i_target_gain = 16'd16;
        i_mute = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_sample", {16'd0, o_sample}, 32'd0);
        check_eq("rst_clip", {31'd0, o_clip}, 32'd0);
        check_eq("rst_ramping", {31'd0, o_ramping}, 32'd0);
        check_eq("rst_gain", {16'd0, o_cur_gain}, 32'd0);
        rst = 1'b1;

        // Fade in from silence
        send(4);
        check_eq("fade_gain4", {16'd0, o_cur_gain}, 32'd1);
        check_eq("fade_ramping", {31'd0, o_ramping}, 32'd1);
        send(59);
        check_eq("fade_gain63", {16'd0, o_cur_gain}, 32'd15);
        check_eq("fade_ramping63", {31'd0, o_ramping}, 32'd1);
        send(1);
        check_eq("fade_gain64", {16'd0, o_cur_gain}, 32'd16);
        check_eq("fade_ramp_done", {31'd0, o_ramping}, 32'd0);
        send(4);
        check_eq("fade_out_valid", {31'd0, o_valid}, 32'd1);
        check_eq("fade_out_sample", {16'd0, o_sample}, 32'h0100);

        // Saturation at unity gain
        pulse(32'h0001_0000);
        check_eq("sat_pos", {16'd0, o_sample}, 32'h7FFF);
        check_eq("sat_pos_clip", {31'd0, o_clip}, 32'd1);
        pulse(32'hFFFF_0000);
        check_eq("sat_neg", {16'd0, o_sample}, 32'h8000);
        check_eq("sat_neg_clip", {31'd0, o_clip}, 32'd1);
        pulse(32'hFFFF_FFFF);
        check_eq("minus_one", {16'd0, o_sample}, 32'hFFFF);
        check_eq("minus_one_clip", {31'd0, o_clip}, 32'd0);
        tick();
        check_eq("idle_valid", {31'd0, o_valid}, 32'd0);
        check_eq("idle_hold", {16'd0, o_sample}, 32'hFFFF);

        // Ramp down 16 -> 8
        i_target_gain = 16'd8;
        i_sample = 32'h0000_0200;
        send(31);
        check_eq("down_gain31", {16'd0, o_cur_gain}, 32'd9);
        send(1);
        check_eq("down_gain32", {16'd0, o_cur_gain}, 32'd8);
        check_eq("down_ramp_done", {31'd0, o_ramping}, 32'd0);
        pulse(32'h0000_0200);
        check_eq("down_sample", {16'd0, o_sample}, 32'h0100);

        // Mute and unmute
        i_target_gain = 16'd16;
        send(32);
        check_eq("mute_pre_gain", {16'd0, o_cur_gain}, 32'd16);
        i_mute = 1'b1;
        send(64);
        check_eq("mute_gain", {16'd0, o_cur_gain}, 32'd0);
        check_eq("mute_ramp_done", {31'd0, o_ramping}, 32'd0);
        pulse(32'h0000_0100);
        check_eq("mute_sample", {16'd0, o_sample}, 32'd0);
        pulse(32'hFFFF_8000);
        check_eq("mute_neg_sample", {16'd0, o_sample}, 32'd0);
        i_mute = 1'b0;
        send(64);
        check_eq("unmute_gain", {16'd0, o_cur_gain}, 32'd16);

        // Reversal mid-ramp keeps the partial step count
        i_mute = 1'b1;
        send(64);
        i_mute = 1'b0;
        send(22);
        check_eq("rev_gain22", {16'd0, o_cur_gain}, 32'd5);
        i_target_gain = 16'd2;
        max_gain = 5;
        send(2);
        check_eq("rev_gain24", {16'd0, o_cur_gain}, 32'd4);
        for (int k = 0; k < 8; k++) begin
            send(1);
            if (int'(o_cur_gain) > max_gain) max_gain = int'(o_cur_gain);
        end
        check_eq("rev_no_overshoot", {31'd0, max_gain <= 6}, 32'd1);
        check_eq("rev_gain_final", {16'd0, o_cur_gain}, 32'd2);
        check_eq("rev_ramp_done", {31'd0, o_ramping}, 32'd0);

        // Async reset mid-ramp with samples in flight
        i_target_gain = 16'd16;
        send(20);
        check_eq("pre_rst_gain", {16'd0, o_cur_gain}, 32'd7);
        i_sample = 32'h0000_0100;
        i_valid = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        i_valid = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("mid_rst_sample", {16'd0, o_sample}, 32'd0);
        check_eq("mid_rst_gain", {16'd0, o_cur_gain}, 32'd0);
        check_eq("mid_rst_ramping", {31'd0, o_ramping}, 32'd0);
        tick();
        rst = 1'b1;
        vcount = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (o_valid) vcount++;
        end
        check_eq("no_stale_valid", vcount, 32'd0);

        // Sparse strobes: one valid every 10 cycles
        for (int s = 0; s < 4; s++) begin
            i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            check_eq("lat_1clk", {31'd0, o_valid}, 32'd0);
            tick();
            check_eq("lat_2clk", {31'd0, o_valid}, 32'd1);
            tick();
            check_eq("lat_3clk", {31'd0, o_valid}, 32'd0);
            for (int k = 0; k < 7; k++) tick();
            if (s == 2) check_eq("sparse_gain3", {16'd0, o_cur_gain}, 32'd0);
        end
        check_eq("sparse_gain4", {16'd0, o_cur_gain}, 32'd1);
        check_eq("sparse_ramping", {31'd0, o_ramping}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
